// File: rtl/ts_out_pacer.sv
// TS output pacer: reads whole packets from the output FIFO, or inserts null packets
// when starved, and emits them at a constant rate with a fixed 2-clock output latency.
module ts_out_pacer #(
  parameter int unsigned PKT_LEN  = 188,
  parameter int unsigned USEDW_W  = 11,
  parameter int unsigned GAP      = 0,
  parameter int unsigned STUFF_EN = 1
) (
  input  logic               clk_27,
  input  logic               RST,
  input  logic [8:0]         FIFO_Q,
  input  logic [USEDW_W-1:0] FIFO_RDUSEDW,
  output logic               FIFO_RDREQ,
  output logic [7:0]         DATA_OUT,
  output logic               P_SYNC_OUT,
  output logic               D_VALID_OUT,
  output logic               DCLK_OUT,
  output logic [15:0]        NULL_CNT,
  output logic               ERR_SYNC
);

  localparam int unsigned CNT_W = 8;
  localparam logic [CNT_W-1:0]   LAST_BYTE = CNT_W'(PKT_LEN - 1);
  localparam logic [CNT_W-1:0]   LAST_GAP  = CNT_W'(GAP - 1);
  localparam logic [USEDW_W-1:0] PKT_WORDS = USEDW_W'(PKT_LEN);
  localparam logic [8:0]         SYNC_WORD = 9'h147;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_STUFF, S_GAP} state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic             rdreq_n;
  logic [7:0]       null_byte;

  // Stage 1: describes the byte slot issued in the previous clock
  logic             s1_valid, s1_read, s1_first;
  logic [7:0]       s1_null;

  assign DCLK_OUT = clk_27;

  always_ff @(posedge clk_27 or negedge RST) begin
    if (!RST) begin
      state      <= S_IDLE;
      cnt        <= '0;
      FIFO_RDREQ <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      FIFO_RDREQ <= rdreq_n;
    end
  end

  // Fill level is only trusted in IDLE, when no read is in flight
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (FIFO_RDUSEDW >= PKT_WORDS) state_n = S_READ;
        else if (STUFF_EN != 0)        state_n = S_STUFF;
      end
      S_READ, S_STUFF: begin
        if (cnt == LAST_BYTE) begin
          cnt_n   = '0;
          state_n = (GAP > 0) ? S_GAP : S_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt == LAST_GAP) begin
          cnt_n   = '0;
          state_n = S_IDLE;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: state_n = S_IDLE;
    endcase
    rdreq_n = (state_n == S_READ);
  end

  // Null packet: PID 0x1FFF header, 0xFF stuffing payload
  always_comb begin
    null_byte = 8'hFF;
    case (cnt)
      CNT_W'(0): null_byte = 8'h47;
      CNT_W'(1): null_byte = 8'h1F;
      CNT_W'(3): null_byte = 8'h10;
      default:   null_byte = 8'hFF;
    endcase
  end

  always_ff @(posedge clk_27 or negedge RST) begin
    if (!RST) begin
      s1_valid <= 1'b0;
      s1_read  <= 1'b0;
      s1_first <= 1'b0;
      s1_null  <= 8'h00;
    end else begin
      s1_valid <= (state == S_READ) || (state == S_STUFF);
      s1_read  <= (state == S_READ);
      s1_first <= (cnt == '0);
      s1_null  <= null_byte;
    end
  end

  // Stage 2: FIFO_Q is valid now, so both sources line up at the output register
  always_ff @(posedge clk_27 or negedge RST) begin
    if (!RST) begin
      DATA_OUT    <= 8'h00;
      P_SYNC_OUT  <= 1'b0;
      D_VALID_OUT <= 1'b0;
      ERR_SYNC    <= 1'b0;
      NULL_CNT    <= 16'h0000;
    end else begin
      D_VALID_OUT <= s1_valid;
      if (s1_valid) begin
        DATA_OUT   <= s1_read ? FIFO_Q[7:0] : s1_null;
        P_SYNC_OUT <= s1_first;
        ERR_SYNC   <= s1_read && s1_first && (FIFO_Q != SYNC_WORD);
        if (!s1_read && s1_first && (NULL_CNT != 16'hFFFF))
          NULL_CNT <= NULL_CNT + 16'd1;
      end else begin
        DATA_OUT   <= 8'h00;
        P_SYNC_OUT <= 1'b0;
        ERR_SYNC   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ts_out_pacer.sv
// Directed bench for ts_out_pacer: three instances cover stuffing (188), gap without
// stuffing, and 204-byte null packets; queue-based FIFO models feed the read side.
module tb_ts_out_pacer;

  logic clk_27 = 1'b0;
  always #5 clk_27 = ~clk_27;

  int checks = 0;
  int errors = 0;

  // Instance A: PKT_LEN=188, GAP=0, STUFF_EN=1
  logic        rst_a = 1'b0;
  logic [8:0]  q_a;
  logic [10:0] usedw_a;
  logic        rdreq_a, psync_a, dv_a, dclk_a, err_a;
  logic [7:0]  data_a;
  logic [15:0] nullcnt_a;
  logic [8:0]  fq_a [$];
  logic        force_a = 1'b0;
  logic [10:0] force_val_a = '0;
  int          rd_cnt_a = 0, under_a = 0, run_a = 0, last_run_a = 0;

  // Instance B: PKT_LEN=188, GAP=10, STUFF_EN=0
  logic        rst_b = 1'b0;
  logic [8:0]  q_b;
  logic [10:0] usedw_b;
  logic        rdreq_b, psync_b, dv_b, dclk_b, err_b;
  logic [7:0]  data_b;
  logic [15:0] nullcnt_b;
  logic [8:0]  fq_b [$];
  int          rd_cnt_b = 0, under_b = 0;

  // Instance C: PKT_LEN=204, GAP=0, STUFF_EN=1, FIFO always empty
  logic        rst_c = 1'b0;
  logic [8:0]  q_c = 9'h000;
  logic [10:0] usedw_c = 11'd0;
  logic        rdreq_c, psync_c, dv_c, dclk_c, err_c;
  logic [7:0]  data_c;
  logic [15:0] nullcnt_c;
  int          rd_cnt_c = 0;

  ts_out_pacer #(.PKT_LEN(188), .USEDW_W(11), .GAP(0), .STUFF_EN(1)) dut_a (
    .clk_27(clk_27), .RST(rst_a), .FIFO_Q(q_a), .FIFO_RDUSEDW(usedw_a),
    .FIFO_RDREQ(rdreq_a), .DATA_OUT(data_a), .P_SYNC_OUT(psync_a),
    .D_VALID_OUT(dv_a), .DCLK_OUT(dclk_a), .NULL_CNT(nullcnt_a), .ERR_SYNC(err_a));

  ts_out_pacer #(.PKT_LEN(188), .USEDW_W(11), .GAP(10), .STUFF_EN(0)) dut_b (
    .clk_27(clk_27), .RST(rst_b), .FIFO_Q(q_b), .FIFO_RDUSEDW(usedw_b),
    .FIFO_RDREQ(rdreq_b), .DATA_OUT(data_b), .P_SYNC_OUT(psync_b),
    .D_VALID_OUT(dv_b), .DCLK_OUT(dclk_b), .NULL_CNT(nullcnt_b), .ERR_SYNC(err_b));

  ts_out_pacer #(.PKT_LEN(204), .USEDW_W(11), .GAP(0), .STUFF_EN(1)) dut_c (
    .clk_27(clk_27), .RST(rst_c), .FIFO_Q(q_c), .FIFO_RDUSEDW(usedw_c),
    .FIFO_RDREQ(rdreq_c), .DATA_OUT(data_c), .P_SYNC_OUT(psync_c),
    .D_VALID_OUT(dv_c), .DCLK_OUT(dclk_c), .NULL_CNT(nullcnt_c), .ERR_SYNC(err_c));

  // Normal-mode FIFO models: q updates on the edge that samples rdreq
  always @(posedge clk_27) begin
    if (rdreq_a) begin
      rd_cnt_a <= rd_cnt_a + 1;
      run_a    <= run_a + 1;
      if (fq_a.size() > 0) q_a <= fq_a.pop_front();
      else under_a <= under_a + 1;
    end else if (run_a != 0) begin
      last_run_a <= run_a;
      run_a      <= 0;
    end
    if (rdreq_b) begin
      rd_cnt_b <= rd_cnt_b + 1;
      if (fq_b.size() > 0) q_b <= fq_b.pop_front();
      else under_b <= under_b + 1;
    end
    if (rdreq_c) rd_cnt_c <= rd_cnt_c + 1;
  end

  always @(negedge clk_27) begin
    usedw_a <= force_a ? force_val_a : 11'(fq_a.size());
    usedw_b <= 11'(fq_b.size());
  end

  logic [7:0] cap_d [0:203];
  logic       cap_p [0:203];
  logic       cap_v [0:203];
  logic       cap_e [0:203];
  logic [7:0] exp_d [0:203];
  logic       exp_p [0:203];
  logic       exp_e [0:203];

  task automatic sample(input int sel, output logic [7:0] d, output logic p, output logic v,
                        output logic e);
    case (sel)
      0:       begin d = data_a; p = psync_a; v = dv_a; e = err_a; end
      1:       begin d = data_b; p = psync_b; v = dv_b; e = err_b; end
      default: begin d = data_c; p = psync_c; v = dv_c; e = err_c; end
    endcase
  endtask

  // Counts falling edges until D_VALID_OUT equals lvl; budget+1 means it never did
  task automatic wait_dv(input int sel, input logic lvl, input int budget, output int n);
    logic [7:0] d;
    logic p, v, e;
    n = 0;
    do begin
      @(negedge clk_27);
      n++;
      sample(sel, d, p, v, e);
    end while (v !== lvl && n <= budget);
  endtask

  task automatic capture(input int sel, input int len);
    logic [7:0] d;
    logic p, v, e;
    for (int i = 0; i < len; i++) begin
      if (i > 0) @(negedge clk_27);
      sample(sel, d, p, v, e);
      cap_d[i] = d; cap_p[i] = p; cap_v[i] = v; cap_e[i] = e;
    end
  endtask

  task automatic push_pkt(input int sel, input logic [8:0] hdr, input logic [7:0] base);
    logic [8:0] w;
    for (int i = 0; i < 188; i++) begin
      w = (i == 0) ? hdr : {1'b0, 8'(int'(base) + i - 1)};
      if (sel == 0) fq_a.push_back(w);
      else fq_b.push_back(w);
    end
  endtask

  task automatic fill_fifo_exp(input logic [7:0] hdr, input logic [7:0] base);
    for (int i = 0; i < 188; i++) begin
      exp_d[i] = (i == 0) ? hdr : 8'(int'(base) + i - 1);
      exp_p[i] = (i == 0);
      exp_e[i] = 1'b0;
    end
  endtask

  task automatic fill_null_exp(input int len);
    for (int i = 0; i < len; i++) begin
      case (i)
        0:       exp_d[i] = 8'h47;
        1:       exp_d[i] = 8'h1F;
        3:       exp_d[i] = 8'h10;
        default: exp_d[i] = 8'hFF;
      endcase
      exp_p[i] = (i == 0);
      exp_e[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    repeat (3) @(negedge clk_27);
    checks++;
    if ({dv_a, psync_a, data_a, rdreq_a, err_a} !== 12'h000) begin
      errors++;
      $display("FAIL reset_outputs: dv=%b ps=%b data=%h rdreq=%b err=%b, required all 0",
               dv_a, psync_a, data_a, rdreq_a, err_a);
    end
    checks++;
    if (nullcnt_a !== 16'h0000) begin
      errors++; $display("FAIL reset_null_cnt: got %h required 0000", nullcnt_a);
    end
    checks++;
    if ({dv_b, dv_c, rdreq_b, rdreq_c} !== 4'b0000) begin
      errors++; $display("FAIL reset_bc: dv_b=%b dv_c=%b rdreq_b=%b rdreq_c=%b, required 0",
                         dv_b, dv_c, rdreq_b, rdreq_c);
    end
    @(posedge clk_27); #1;
    checks++;
    if ({dclk_a, dclk_b, dclk_c} !== 3'b111) begin
      errors++; $display("FAIL dclk_passthrough: got %b required 111", {dclk_a, dclk_b, dclk_c});
    end
  endtask

  task automatic test_null_stuffing();
    int n, bad, fb;
    @(negedge clk_27);
    rst_a = 1'b1;
    wait_dv(0, 1'b1, 20, n);
    checks++;
    if (n != 3) begin errors++; $display("FAIL first_valid_latency: got %0d required 3", n); end
    fill_null_exp(188);
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (nullcnt_a !== 16'(k)) begin
        errors++; $display("FAIL null_cnt_%0d: got %0d required %0d", k, nullcnt_a, k);
      end
      capture(0, 188);
      bad = 0; fb = 0;
      for (int i = 0; i < 188; i++)
        if (cap_d[i] !== exp_d[i] || cap_p[i] !== exp_p[i] || cap_v[i] !== 1'b1 ||
            cap_e[i] !== exp_e[i]) begin
          if (bad == 0) fb = i;
          bad++;
        end
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL null_pkt_%0d: %0d bad bytes, byte %0d got %h required %h",
                           k, bad, fb, cap_d[fb], exp_d[fb]);
      end
      @(negedge clk_27);
      checks++;
      if ({dv_a, psync_a, data_a} !== 10'h000) begin
        errors++; $display("FAIL idle_slot_%0d: dv=%b ps=%b data=%h required 0", k, dv_a, psync_a, data_a);
      end
      wait_dv(0, 1'b1, 4, n);
      checks++;
      if (n != 1) begin errors++; $display("FAIL null_period_%0d: got %0d required 1", k, n); end
    end
  endtask

  task automatic test_fifo_packets();
    int n, bad, fb, r0;
    r0 = rd_cnt_a;
    push_pkt(0, 9'h147, 8'h00);
    push_pkt(0, 9'h147, 8'h00);
    fill_fifo_exp(8'h47, 8'h00);
    wait_dv(0, 1'b0, 400, n);
    for (int k = 1; k <= 2; k++) begin
      wait_dv(0, 1'b1, 4, n);
      checks++;
      if (n != 1) begin errors++; $display("FAIL fifo_pkt_start_%0d: got %0d required 1", k, n); end
      capture(0, 188);
      bad = 0; fb = 0;
      for (int i = 0; i < 188; i++)
        if (cap_d[i] !== exp_d[i] || cap_p[i] !== exp_p[i] || cap_v[i] !== 1'b1 ||
            cap_e[i] !== exp_e[i]) begin
          if (bad == 0) fb = i;
          bad++;
        end
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL fifo_pkt_%0d: %0d bad bytes, byte %0d got %h required %h",
                           k, bad, fb, cap_d[fb], exp_d[fb]);
      end
      checks++;
      if (last_run_a != 188) begin
        errors++; $display("FAIL rdreq_run_%0d: got %0d required 188", k, last_run_a);
      end
      wait_dv(0, 1'b0, 4, n);
    end
    wait_dv(0, 1'b1, 4, n);
    checks++;
    if (data_a !== 8'h47 || nullcnt_a !== 16'd5) begin
      errors++; $display("FAIL stuffing_resumes: data=%h cnt=%0d required 47/5", data_a, nullcnt_a);
    end
    checks++;
    if (rd_cnt_a - r0 != 376 || under_a != 0) begin
      errors++; $display("FAIL rdreq_total: got %0d (underflow %0d) required 376 (0)",
                         rd_cnt_a - r0, under_a);
    end
  endtask

  task automatic test_usedw_threshold();
    int n, bad, fb, r0;
    force_val_a = 11'd187;
    force_a = 1'b1;
    push_pkt(0, 9'h147, 8'h40);
    r0 = rd_cnt_a;
    wait_dv(0, 1'b0, 400, n);
    wait_dv(0, 1'b1, 4, n);
    checks++;
    if (n != 1 || data_a !== 8'h47 || nullcnt_a !== 16'd6 || rd_cnt_a != r0) begin
      errors++; $display("FAIL stuff_at_187: n=%0d data=%h cnt=%0d reads=%0d required 1/47/6/0",
                         n, data_a, nullcnt_a, rd_cnt_a - r0);
    end
    repeat (50) @(negedge clk_27);
    force_val_a = 11'd188;
    wait_dv(0, 1'b0, 400, n);
    wait_dv(0, 1'b1, 4, n);
    force_a = 1'b0;
    fill_fifo_exp(8'h47, 8'h40);
    capture(0, 188);
    bad = 0; fb = 0;
    for (int i = 0; i < 188; i++)
      if (cap_d[i] !== exp_d[i] || cap_p[i] !== exp_p[i] || cap_v[i] !== 1'b1 ||
          cap_e[i] !== exp_e[i]) begin
        if (bad == 0) fb = i;
        bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL read_after_raise: %0d bad bytes, byte %0d got %h required %h",
                         bad, fb, cap_d[fb], exp_d[fb]);
    end
    checks++;
    if (rd_cnt_a - r0 != 188) begin
      errors++; $display("FAIL threshold_reads: got %0d required 188", rd_cnt_a - r0);
    end
  endtask

  task automatic test_sync_error();
    int n, bad, fb, errs;
    push_pkt(0, 9'h046, 8'h20);
    wait_dv(0, 1'b1, 4, n);
    checks++;
    if (n != 2 || data_a !== 8'h47 || nullcnt_a !== 16'd7 || err_a !== 1'b0) begin
      errors++; $display("FAIL null_before_bad: n=%0d data=%h cnt=%0d err=%b required 2/47/7/0",
                         n, data_a, nullcnt_a, err_a);
    end
    wait_dv(0, 1'b0, 400, n);
    wait_dv(0, 1'b1, 4, n);
    capture(0, 188);
    fill_fifo_exp(8'h46, 8'h20);
    exp_e[0] = 1'b1;
    checks++;
    if (cap_d[0] !== 8'h46 || cap_p[0] !== 1'b1 || cap_e[0] !== 1'b1) begin
      errors++; $display("FAIL sync_err_byte0: data=%h ps=%b err=%b required 46/1/1",
                         cap_d[0], cap_p[0], cap_e[0]);
    end
    bad = 0; fb = 0; errs = 0;
    for (int i = 0; i < 188; i++) begin
      if (cap_e[i] === 1'b1) errs++;
      if (cap_d[i] !== exp_d[i] || cap_p[i] !== exp_p[i] || cap_v[i] !== 1'b1 ||
          cap_e[i] !== exp_e[i]) begin
        if (bad == 0) fb = i;
        bad++;
      end
    end
    checks++;
    if (errs != 1 || bad != 0) begin
      errors++; $display("FAIL sync_err_pulse: %0d err clocks, %0d bad bytes (first %0d), required 1/0",
                         errs, bad, fb);
    end
  endtask

  task automatic test_reset_midread();
    int n;
    push_pkt(0, 9'h147, 8'h00);
    wait_dv(0, 1'b1, 4, n);
    wait_dv(0, 1'b0, 400, n);
    wait_dv(0, 1'b1, 4, n);
    repeat (98) @(negedge clk_27);
    checks++;
    if (dv_a !== 1'b1 || data_a !== 8'd97 || rdreq_a !== 1'b1) begin
      errors++; $display("FAIL midread_byte98: dv=%b data=%h rdreq=%b required 1/61/1",
                         dv_a, data_a, rdreq_a);
    end
    rst_a = 1'b0;
    #1;
    checks++;
    if ({dv_a, psync_a, data_a, rdreq_a, err_a} !== 12'h000 || nullcnt_a !== 16'h0000) begin
      errors++; $display("FAIL async_reset: dv=%b ps=%b data=%h rdreq=%b err=%b cnt=%h required 0",
                         dv_a, psync_a, data_a, rdreq_a, err_a, nullcnt_a);
    end
    fq_a.delete();
    repeat (2) @(negedge clk_27);
    rst_a = 1'b1;
    wait_dv(0, 1'b1, 20, n);
    checks++;
    if (n != 3 || data_a !== 8'h47 || psync_a !== 1'b1 || nullcnt_a !== 16'd1) begin
      errors++; $display("FAIL fresh_after_reset: n=%0d data=%h ps=%b cnt=%0d required 3/47/1/1",
                         n, data_a, psync_a, nullcnt_a);
    end
  endtask

  task automatic test_gap_nostuff();
    int n, bad, fb, r0;
    rst_b = 1'b1;
    r0 = rd_cnt_b;
    wait_dv(1, 1'b1, 300, n);
    checks++;
    if (n != 301 || rd_cnt_b != r0) begin
      errors++; $display("FAIL empty_no_stuff: n=%0d reads=%0d required 301/0", n, rd_cnt_b - r0);
    end
    push_pkt(1, 9'h147, 8'h10);
    wait_dv(1, 1'b1, 20, n);
    fill_fifo_exp(8'h47, 8'h10);
    capture(1, 188);
    bad = 0; fb = 0;
    for (int i = 0; i < 188; i++)
      if (cap_d[i] !== exp_d[i] || cap_p[i] !== exp_p[i] || cap_v[i] !== 1'b1 ||
          cap_e[i] !== exp_e[i]) begin
        if (bad == 0) fb = i;
        bad++;
      end
    checks++;
    if (n > 5 || bad != 0) begin
      errors++; $display("FAIL gap_single_pkt: start %0d, %0d bad bytes (first %0d), required <=5/0",
                         n, bad, fb);
    end
    wait_dv(1, 1'b1, 300, n);
    checks++;
    if (n != 301 || rd_cnt_b - r0 != 188 || nullcnt_b !== 16'd0) begin
      errors++; $display("FAIL idle_after_pkt: n=%0d reads=%0d nulls=%0d required 301/188/0",
                         n, rd_cnt_b - r0, nullcnt_b);
    end
    push_pkt(1, 9'h147, 8'h60);
    push_pkt(1, 9'h147, 8'h90);
    wait_dv(1, 1'b1, 20, n);
    capture(1, 188);
    fill_fifo_exp(8'h47, 8'h60);
    bad = 0; fb = 0;
    for (int i = 0; i < 188; i++)
      if (cap_d[i] !== exp_d[i] || cap_p[i] !== exp_p[i] || cap_v[i] !== 1'b1) begin
        if (bad == 0) fb = i;
        bad++;
      end
    wait_dv(1, 1'b1, 40, n);
    checks++;
    if (n != 12) begin errors++; $display("FAIL gap_invalid_clocks: got %0d required 11", n - 1); end
    capture(1, 188);
    fill_fifo_exp(8'h47, 8'h90);
    for (int i = 0; i < 188; i++)
      if (cap_d[i] !== exp_d[i] || cap_p[i] !== exp_p[i] || cap_v[i] !== 1'b1) begin
        if (bad == 0) fb = 200 + i;
        bad++;
      end
    checks++;
    if (bad != 0 || under_b != 0) begin
      errors++; $display("FAIL gap_pair_data: %0d bad bytes (first %0d), underflow %0d, required 0/0",
                         bad, fb, under_b);
    end
  endtask

  task automatic test_pkt204();
    int n, bad, fb;
    rst_c = 1'b1;
    wait_dv(2, 1'b1, 20, n);
    checks++;
    if (n != 3) begin errors++; $display("FAIL c_first_latency: got %0d required 3", n); end
    capture(2, 204);
    fill_null_exp(204);
    bad = 0; fb = 0;
    for (int i = 0; i < 204; i++)
      if (cap_d[i] !== exp_d[i] || cap_p[i] !== exp_p[i] || cap_v[i] !== 1'b1 ||
          cap_e[i] !== exp_e[i]) begin
        if (bad == 0) fb = i;
        bad++;
      end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL null_204: %0d bad bytes, byte %0d got %h required %h",
                         bad, fb, cap_d[fb], exp_d[fb]);
    end
    wait_dv(2, 1'b1, 4, n);
    checks++;
    if (n != 2 || nullcnt_c !== 16'd2 || rd_cnt_c != 0) begin
      errors++; $display("FAIL period_205: n=%0d cnt=%0d reads=%0d required 2/2/0",
                         n, nullcnt_c, rd_cnt_c);
    end
  endtask

  initial begin
    test_reset();
    test_null_stuffing();
    test_fifo_packets();
    test_usedw_threshold();
    test_sync_error();
    test_reset_midread();
    test_gap_nostuff();
    test_pkt204();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded 2 ms");
    $fatal(1);
  end

endmodule
